// File: rtl/button_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : button_event_ctrl
// Summary  : Converts debounced button levels into press and auto-repeat
//            events. Events leave through one shared round-robin
//            valid/ready channel.
// Revision : 1.0
// ============================================================================
module button_event_ctrl #(
    parameter int NBTN          = 4,
    parameter int IDW           = 2,
    parameter int HOLD_DELAY    = 10000000,
    parameter int REPEAT_PERIOD = 2500000,
    parameter int TBITS         = 24
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NBTN-1:0] btn_clean,
    input  logic            enable,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [IDW-1:0]  evt_id,
    output logic            evt_type,
    output logic [NBTN-1:0] pending
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_RPT  = 2'd2
    } btn_state_e;

    localparam logic [TBITS-1:0] c_hold_last = TBITS'(HOLD_DELAY - 1);
    localparam logic [TBITS-1:0] c_rpt_last  = TBITS'(REPEAT_PERIOD - 1);

    logic [NBTN-1:0] btn_prev_q;
    logic [NBTN-1:0] btn_prev_d;
    logic [NBTN-1:0] rise;
    logic [NBTN-1:0] pend_vec;
    logic [NBTN-1:0] ptype_vec;
    logic [NBTN-1:0] cand;
    logic [NBTN-1:0] grant;

    logic            valid_q;
    logic            valid_d;
    logic [IDW-1:0]  id_q;
    logic [IDW-1:0]  id_d;
    logic            etype_q;
    logic            etype_d;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  ptr_d;

    logic            load;
    logic            hi_found;
    logic            lo_found;
    logic [IDW-1:0]  hi_id;
    logic [IDW-1:0]  lo_id;
    logic            hi_type;
    logic            lo_type;
    logic            sel_found;
    logic [IDW-1:0]  sel_id;
    logic            sel_type;

    always_comb begin
        btn_prev_d = btn_clean;
    end

    assign rise = btn_clean & ~btn_prev_q;

    // Reset to all ones so a button held across reset release is not a press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_prev_q <= '1;
        end else begin
            btn_prev_q <= btn_prev_d;
        end
    end

    for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
        btn_state_e       state_q;
        btn_state_e       state_d;
        logic [TBITS-1:0] timer_q;
        logic [TBITS-1:0] timer_d;
        logic             pend_q;
        logic             pend_d;
        logic             ptype_q;
        logic             ptype_d;
        logic             press_cap;
        logic             rpt_cap;
        logic             pend_left;

        always_comb begin
            state_d   = state_q;
            timer_d   = timer_q;
            press_cap = 1'b0;
            rpt_cap   = 1'b0;
            if (!enable) begin
                state_d = ST_IDLE;
                timer_d = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rise[gi]) begin
                            press_cap = 1'b1;
                            timer_d   = '0;
                            state_d   = ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (!btn_clean[gi]) begin
                            state_d = ST_IDLE;
                            timer_d = '0;
                        end else if (timer_q == c_hold_last) begin
                            rpt_cap = 1'b1;
                            timer_d = '0;
                            state_d = ST_RPT;
                        end else begin
                            timer_d = timer_q + TBITS'(1);
                        end
                    end
                    ST_RPT: begin
                        if (!btn_clean[gi]) begin
                            state_d = ST_IDLE;
                            timer_d = '0;
                        end else if (timer_q == c_rpt_last) begin
                            rpt_cap = 1'b1;
                            timer_d = '0;
                        end else begin
                            timer_d = timer_q + TBITS'(1);
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end
                endcase
            end

            // A grant this cycle frees the slot, so a capture in the same cycle lands.
            pend_left = pend_q & ~grant[gi];
            pend_d    = pend_left;
            ptype_d   = ptype_q;
            if (!enable) begin
                pend_d = 1'b0;
            end else if (press_cap) begin
                pend_d  = 1'b1;
                ptype_d = 1'b0;
            end else if (rpt_cap && !(pend_left && !ptype_q)) begin
                pend_d  = 1'b1;
                ptype_d = 1'b1;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= ST_IDLE;
                timer_q <= '0;
                pend_q  <= 1'b0;
                ptype_q <= 1'b0;
            end else begin
                state_q <= state_d;
                timer_q <= timer_d;
                pend_q  <= pend_d;
                ptype_q <= ptype_d;
            end
        end

        assign pend_vec[gi]  = pend_q;
        assign ptype_vec[gi] = ptype_q;
    end

    assign cand = pend_vec & {NBTN{enable}};
    assign load = ~valid_q | evt_ready;

    // Rotating priority: indices above the pointer first, then 0..pointer.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        hi_type  = 1'b0;
        lo_type  = 1'b0;
        for (int j = NBTN - 1; j >= 0; j--) begin
            if (cand[j]) begin
                if (j > int'(ptr_q)) begin
                    hi_found = 1'b1;
                    hi_id    = IDW'(j);
                    hi_type  = ptype_vec[j];
                end else begin
                    lo_found = 1'b1;
                    lo_id    = IDW'(j);
                    lo_type  = ptype_vec[j];
                end
            end
        end
        sel_found = hi_found | lo_found;
        sel_id    = hi_found ? hi_id : lo_id;
        sel_type  = hi_found ? hi_type : lo_type;
    end

    always_comb begin
        grant = '0;
        for (int j = 0; j < NBTN; j++) begin
            grant[j] = load & sel_found & (sel_id == IDW'(j));
        end
    end

    always_comb begin
        valid_d = valid_q;
        id_d    = id_q;
        etype_d = etype_q;
        ptr_d   = ptr_q;
        if (load) begin
            if (sel_found) begin
                valid_d = 1'b1;
                id_d    = sel_id;
                etype_d = sel_type;
                ptr_d   = sel_id;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            id_q    <= '0;
            etype_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            valid_q <= valid_d;
            id_q    <= id_d;
            etype_q <= etype_d;
            ptr_q   <= ptr_d;
        end
    end

    assign evt_valid = valid_q;
    assign evt_id    = id_q;
    assign evt_type  = etype_q;
    assign pending   = pend_vec;

endmodule
`default_nettype wire

// File: tb/tb_button_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_event_ctrl
// Summary  : Directed vector bench for button_event_ctrl (NBTN=4,
//            HOLD_DELAY=10, REPEAT_PERIOD=4).
// Revision : 1.0
// ============================================================================
module tb_button_event_ctrl;

    localparam int NBTN          = 4;
    localparam int IDW           = 2;
    localparam int HOLD_DELAY    = 10;
    localparam int REPEAT_PERIOD = 4;
    localparam int TBITS         = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [NBTN-1:0] btn_clean;
    logic            enable;
    logic            evt_valid;
    logic            evt_ready;
    logic [IDW-1:0]  evt_id;
    logic            evt_type;
    logic [NBTN-1:0] pending;

    typedef struct packed {
        logic [3:0] btn;
        logic       en;
        logic       rdy;
        logic       ev;
        logic [1:0] id;
        logic       ty;
        logic [3:0] pend;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    button_event_ctrl #(
        .NBTN          (NBTN),
        .IDW           (IDW),
        .HOLD_DELAY    (HOLD_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD),
        .TBITS         (TBITS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_clean (btn_clean),
        .enable    (enable),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_type  (evt_type),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    function automatic void push(input logic [3:0] b, input logic en, input logic rdy,
                                 input logic ev, input logic [1:0] id, input logic ty,
                                 input logic [3:0] p);
        vec_t v;
        v.btn  = b;
        v.en   = en;
        v.rdy  = rdy;
        v.ev   = ev;
        v.id   = id;
        v.ty   = ty;
        v.pend = p;
        vecs.push_back(v);
    endfunction

    // id/type are only meaningful while evt_valid is expected high.
    task automatic check_vec(input string tag, input int idx, input logic ev,
                             input logic [1:0] id, input logic ty, input logic [3:0] p);
        n_vec++;
        if (evt_valid !== ev || pending !== p || (ev && (evt_id !== id || evt_type !== ty))) begin
            n_err++;
            $display("FAIL %s[%0d]: got valid=%b id=%0d type=%b pending=%b, want valid=%b id=%0d type=%b pending=%b",
                     tag, idx, evt_valid, evt_id, evt_type, pending, ev, id, ty, p);
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [1:0] id,
                             input logic ty, input logic [3:0] p);
        n_vec++;
        if (evt_valid !== ev || pending !== p || evt_id !== id || evt_type !== ty) begin
            n_err++;
            $display("FAIL %s: got valid=%b id=%0d type=%b pending=%b, want valid=%b id=%0d type=%b pending=%b",
                     tag, evt_valid, evt_id, evt_type, pending, ev, id, ty, p);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single press of button 2
        push(4'b0000, 1, 1, 0, 0, 0, 4'b0000);
        push(4'b0100, 1, 1, 0, 0, 0, 4'b0100);
        push(4'b0100, 1, 1, 1, 2, 0, 4'b0000);
        push(4'b0100, 1, 1, 0, 0, 0, 4'b0000);
        push(4'b0000, 1, 1, 0, 0, 0, 4'b0000);
        push(4'b0000, 1, 1, 0, 0, 0, 4'b0000);
        // Press button 3 so the pointer sits at 3
        push(4'b1000, 1, 1, 0, 0, 0, 4'b1000);
        push(4'b0000, 1, 1, 1, 3, 0, 4'b0000);
        push(4'b0000, 1, 1, 0, 0, 0, 4'b0000);
        // Round robin with backpressure
        push(4'b1011, 1, 0, 0, 0, 0, 4'b1011);
        push(4'b1011, 1, 0, 1, 0, 0, 4'b1010);
        push(4'b1011, 1, 0, 1, 0, 0, 4'b1010);
        push(4'b0000, 1, 0, 1, 0, 0, 4'b1010);
        push(4'b0000, 1, 1, 1, 1, 0, 4'b1000);
        push(4'b0000, 1, 1, 1, 3, 0, 4'b0000);
        push(4'b0000, 1, 1, 0, 0, 0, 4'b0000);
        // Hold button 1 for 30 cycles: press, repeats captured at 10,14,18,22,26
        for (int c = 0; c < 34; c++) begin
            logic       ev;
            logic [3:0] p;
            ev = (c == 1) || (c == 11) || (c == 15) || (c == 19) || (c == 23) || (c == 27);
            p  = ((c == 0) || (c == 10) || (c == 14) || (c == 18) || (c == 22) || (c == 26))
                 ? 4'b0010 : 4'b0000;
            push((c < 30) ? 4'b0010 : 4'b0000, 1, 1, ev, 2'd1, (c != 1), p);
        end
        // Coalescing: output busy with button 3, button 0 press pending, repeats dropped
        push(4'b1000, 1, 0, 0, 0, 0, 4'b1000);
        push(4'b0000, 1, 0, 1, 3, 0, 4'b0000);
        for (int c = 0; c < 25; c++) begin
            push(4'b0001, 1, 0, 1, 3, 0, 4'b0001);
        end
        push(4'b0000, 1, 0, 1, 3, 0, 4'b0001);
        push(4'b0000, 1, 1, 1, 0, 0, 4'b0000);
        push(4'b0000, 1, 1, 0, 0, 0, 4'b0000);
        // Simultaneous grant and capture at cycle 14, then repeat merge at 18
        for (int c = 0; c < 22; c++) begin
            logic       rdy;
            logic       ev;
            logic [3:0] p;
            rdy = (c == 14) || (c == 20) || (c == 21);
            ev  = (c >= 1) && (c <= 20);
            p   = ((c == 0) || ((c >= 10) && (c <= 19))) ? 4'b0010 : 4'b0000;
            push((c < 19) ? 4'b0010 : 4'b0000, 1, rdy, ev, 2'd1, (c >= 14), p);
        end
        // enable=0 flushes pending but keeps the presented event
        push(4'b0001, 1, 0, 0, 0, 0, 4'b0001);
        push(4'b0111, 1, 0, 1, 0, 0, 4'b0110);
        push(4'b0111, 0, 0, 1, 0, 0, 4'b0000);
        push(4'b1111, 0, 0, 1, 0, 0, 4'b0000);
        push(4'b1111, 0, 1, 0, 0, 0, 4'b0000);
        push(4'b1111, 1, 1, 0, 0, 0, 4'b0000);
        push(4'b1111, 1, 1, 0, 0, 0, 4'b0000);
        push(4'b0000, 1, 1, 0, 0, 0, 4'b0000);

        reset     = 1'b0;
        btn_clean = 4'b0000;
        enable    = 1'b1;
        evt_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset_state", 0, 2'd0, 0, 4'b0000);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            btn_clean = vecs[i].btn;
            enable    = vecs[i].en;
            evt_ready = vecs[i].rdy;
            @(posedge clk);
            #1;
            check_vec("vec", i, vecs[i].ev, vecs[i].id, vecs[i].ty, vecs[i].pend);
        end

        // Asynchronous reset in the middle of a presented event
        btn_clean = 4'b0100;
        evt_ready = 1'b0;
        @(posedge clk);
        #1;
        check_all("rst_seq_pend", 0, 2'd0, 0, 4'b0100);
        @(posedge clk);
        #1;
        check_all("rst_seq_valid", 1, 2'd2, 0, 4'b0000);
        reset = 1'b0;
        #1;
        check_all("async_reset", 0, 2'd0, 0, 4'b0000);

        // Button 2 held through reset release must not produce any event
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b1;
        evt_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk);
            #1;
            check_vec("held_thru_reset", c, 0, 2'd0, 0, 4'b0000);
        end
        btn_clean = 4'b0000;
        repeat (2) begin
            @(posedge clk);
            #1;
            check_vec("after_release", 0, 0, 2'd0, 0, 4'b0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_event_ctrl.md
Name: button_event_ctrl

Overview:
Event controller placed downstream of a bank of per-button debounce filters. It turns clean, level-type button signals into discrete press and auto-repeat events. All buttons share one event output channel, granted round-robin under a valid/ready handshake. Consumers such as menu or mode FSMs read one event at a time instead of polling raw levels.

Parameters:
NBTN, 4, number of debounced button inputs (2..16)
IDW, 2, width of evt_id; must satisfy 2^IDW >= NBTN
HOLD_DELAY, 10000000, cycles a button must stay held after its press capture before the first repeat event (>= 2)
REPEAT_PERIOD, 2500000, cycles between successive repeat events while held (>= 2)
TBITS, 24, width of each per-button hold timer; must hold max(HOLD_DELAY, REPEAT_PERIOD)

Ports:
clk  in  1  system clock; all state updates on posedge
reset  in  1  asynchronous, active-low reset; all state cleared immediately while low
btn_clean  in  NBTN  debounced button levels, 1 = pressed, synchronous to clk
enable  in  1  1 = capture events; 0 = flush pending flags and timers
evt_valid  out  1  event available on evt_id/evt_type
evt_ready  in  1  consumer accepts the event when evt_valid & evt_ready at posedge
evt_id  out  IDW  index of the button that generated the event
evt_type  out  1  0 = press, 1 = auto-repeat
pending  out  NBTN  per-button pending-event flags (status only)

Behaviour:
- Reset (reset=0, asynchronous):
  - evt_valid=0, evt_id=0, evt_type=0, pending=0, all timers=0.
  - Per-button FSMs go to IDLE; round-robin pointer = 0.
  - btn_prev is set to all ones, so a button already held when reset releases produces no press event.
- Edge capture: btn_prev <= btn_clean every cycle. A rise is btn_clean[i] & ~btn_prev[i].
- Per-button FSM, states IDLE / HOLD / RPT:
  - IDLE: on a rise with enable=1, set pending[i] with type press, clear the timer, go to HOLD.
  - HOLD: if btn_clean[i]=0, go to IDLE. Otherwise the timer increments; when it reaches HOLD_DELAY-1, capture a repeat event, clear the timer, go to RPT.
  - RPT: if btn_clean[i]=0, go to IDLE. Otherwise the timer increments; at REPEAT_PERIOD-1, capture a repeat event and clear the timer.
  - Net effect: the first repeat is captured exactly HOLD_DELAY cycles after the press capture, then one every REPEAT_PERIOD cycles.
- Pending coalescing:
  - One pending slot per button.
  - A repeat arriving while a press is pending is dropped; the press is kept.
  - A repeat arriving while a repeat is pending merges into the existing one.
  - A press arriving while anything is pending overwrites the type to press.
- Output register:
  - It loads when evt_valid=0, or when evt_valid & evt_ready.
  - On load it picks the first set pending bit, searching round-robin from pointer+1 (mod NBTN) upward.
  - It drives evt_id/evt_type from the winner, sets evt_valid=1, clears the winner's pending bit, and sets the pointer to the winner.
  - If no bit is pending at load, evt_valid goes to 0.
- Handshake: evt_id and evt_type are stable while evt_valid=1 and evt_ready=0. With continuous ready, one event is accepted per cycle.
- Latency: a rise seen at posedge N sets pending at N. With the output idle, evt_valid=1 after posedge N+1.
- Simultaneous set and grant: if the winner's pending bit is cleared in the same cycle a new event is captured for that button, the new event wins and pending stays 1.
- Release while pending: releasing a button does not clear its pending event.
- enable=0:
  - All pending bits are cleared, all FSMs forced to IDLE, and no captures occur.
  - An event already presented (evt_valid=1) stays until accepted.
  - Rises while enable=0 are lost.
- Timers never wrap: they are cleared at each terminal count or on leaving HOLD/RPT.

Test Plan:
1. Config for all tests: NBTN=4, HOLD_DELAY=10, REPEAT_PERIOD=4.
2. Single press: reset low then high, evt_ready=1; raise btn_clean[2] for 3 cycles -> exactly one event, evt_id=2, evt_type=0, evt_valid high 2 cycles after the rise sample, no repeats.
3. Hold: btn_clean[1] held 30 cycles with the rise captured at cycle 0 -> press event, then repeats captured at cycles 10, 14, 18, 22, 26 (5 repeats, evt_type=1, evt_id=1); none after release.
4. Round-robin/backpressure: evt_ready=0; rise btn_clean[0], [1], [3] in the same cycle -> pending=4'b1011, evt_id=0 held stable; then evt_ready=1 -> ids 0, 1, 3 on consecutive cycles, then evt_valid=0.
5. Coalescing: evt_ready=0, hold btn[0] 25 cycles -> only one event for button 0 presented (press); repeats are dropped while the press is pending; pending[0]=1 until accepted.
6. Reset/enable: hold btn[2] through reset deassertion -> no event. Drop reset low mid-event -> evt_valid=0 immediately. Set enable=0 with pending=4'b0110 -> pending=0 next cycle, the presented event is still accepted.
